// File: rtl/packet_credit_scheduler.sv
// Packet-granular weighted round-robin output scheduler; 1-cycle arbitration bubble, then one beat per cycle.
// Backpressure: out_ready_i passes straight to the granted channel; zero credits stall with grant held.
module packet_credit_scheduler #(
   parameter int CHANNEL_NUMBER       = 5,
   parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
   parameter int LEN_WIDTH            = 8,
   parameter int WEIGHT_WIDTH         = 4,
   parameter int CREDITS              = 8,
   parameter int CREDIT_WIDTH         = $clog2(CREDITS + 1)
) (
   input  logic                                   clk_i,
   input  logic                                   rst_n_i,
   input  logic [CHANNEL_NUMBER-1:0]              in_valid_i,
   input  logic [CHANNEL_NUMBER-1:0]              in_is_header_i,
   input  logic [CHANNEL_NUMBER*LEN_WIDTH-1:0]    in_len_i,
   output logic [CHANNEL_NUMBER-1:0]              in_ready_o,
   output logic                                   out_valid_o,
   input  logic                                   out_ready_i,
   output logic [CHANNEL_NUMBER_WIDTH-1:0]        grant_o,
   output logic                                   busy_o,
   input  logic [CHANNEL_NUMBER*WEIGHT_WIDTH-1:0] weight_i,
   input  logic                                   credit_return_i,
   output logic [CREDIT_WIDTH-1:0]                credits_o,
   output logic                                   credit_err_o
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                          state_q, state_d;
   logic [CHANNEL_NUMBER_WIDTH-1:0] grant_q, grant_d;
   logic [CHANNEL_NUMBER_WIDTH-1:0] ptr_q, ptr_d;
   logic [WEIGHT_WIDTH-1:0]         quota_q, quota_d;
   logic [LEN_WIDTH-1:0]            beats_q, beats_d;
   logic [CREDIT_WIDTH-1:0]         credits_q, credits_d;
   logic                            err_q, err_d;

   logic [CHANNEL_NUMBER-1:0]       elig;
   logic                            found;
   logic [CHANNEL_NUMBER_WIDTH-1:0] winner;
   logic                            busy, ok, out_vld, fire, pkt_end;
   logic [LEN_WIDTH-1:0]            cur_len;
   logic [WEIGHT_WIDTH-1:0]         cur_w;
   logic [WEIGHT_WIDTH:0]           w_eff, quota_inc;
   logic [CHANNEL_NUMBER-1:0]       rdy;

   // Rotating priority search: first eligible header at or after ptr_q.
   always_comb begin : arb
      int idx;
      idx    = 0;
      elig   = in_valid_i & in_is_header_i;
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < CHANNEL_NUMBER; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= CHANNEL_NUMBER) idx = idx - CHANNEL_NUMBER;
         if (!found && elig[idx]) begin
            found  = 1'b1;
            winner = CHANNEL_NUMBER_WIDTH'(idx);
         end
      end
   end

   always_comb begin
      busy      = (state_q == BUSY);
      ok        = (credits_q != '0);
      out_vld   = busy && in_valid_i[grant_q] && ok;
      rdy       = '0;
      if (busy && out_ready_i && ok) rdy[grant_q] = 1'b1;
      fire      = out_vld && out_ready_i;
      cur_len   = in_len_i[grant_q*LEN_WIDTH +: LEN_WIDTH];
      cur_w     = weight_i[grant_q*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      w_eff     = (cur_w == '0) ? (WEIGHT_WIDTH+1)'(1) : {1'b0, cur_w};
      quota_inc = {1'b0, quota_q} + (WEIGHT_WIDTH+1)'(1);
      // beats_q == 0 inside BUSY means the header has not fired yet.
      pkt_end   = fire && (((beats_q == '0) && (cur_len == '0)) || (beats_q == LEN_WIDTH'(1)));
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      quota_d = quota_q;
      beats_d = beats_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BUSY;
               grant_d = winner;
               if (winner != grant_q) quota_d = '0;
            end
         end
         BUSY: begin
            if (fire) beats_d = (beats_q == '0) ? cur_len : beats_q - LEN_WIDTH'(1);
            if (pkt_end) begin
               state_d = IDLE;
               beats_d = '0;
               if (quota_inc < w_eff) begin
                  ptr_d   = grant_q;
                  quota_d = quota_q + WEIGHT_WIDTH'(1);
               end else begin
                  ptr_d   = (grant_q == CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1)) ?
                            '0 : grant_q + CHANNEL_NUMBER_WIDTH'(1);
                  quota_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      credits_d = credits_q;
      err_d     = err_q;
      case ({fire, credit_return_i})
         2'b10: credits_d = credits_q - CREDIT_WIDTH'(1);
         2'b01: begin
            if (credits_q == CREDIT_WIDTH'(CREDITS)) err_d = 1'b1;
            else credits_d = credits_q + CREDIT_WIDTH'(1);
         end
         default: credits_d = credits_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         ptr_q     <= '0;
         quota_q   <= '0;
         beats_q   <= '0;
         credits_q <= CREDIT_WIDTH'(CREDITS);
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         quota_q   <= quota_d;
         beats_q   <= beats_d;
         credits_q <= credits_d;
         err_q     <= err_d;
      end
   end

   assign in_ready_o   = rdy;
   assign out_valid_o  = out_vld;
   assign grant_o      = grant_q;
   assign busy_o       = busy;
   assign credits_o    = credits_q;
   assign credit_err_o = err_q;

endmodule

// File: tb/tb_packet_credit_scheduler.sv
// Directed bench for packet_credit_scheduler: per-channel packet sources plus a grant-order scoreboard.
module tb_packet_credit_scheduler;
   localparam int N = 5;

   logic         clk_i = 1'b0;
   logic         rst_n_i;
   logic [N-1:0] in_valid_i, in_is_header_i, in_ready_o;
   logic [N*8-1:0] in_len_i;
   logic         out_valid_o, out_ready_i, busy_o, credit_return_i, credit_err_o;
   logic [2:0]   grant_o;
   logic [N*4-1:0] weight_i;
   logic [3:0]   credits_o;

   packet_credit_scheduler dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_is_header_i(in_is_header_i),
      .in_len_i(in_len_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .grant_o(grant_o), .busy_o(busy_o), .weight_i(weight_i), .credit_return_i(credit_return_i),
      .credits_o(credits_o), .credit_err_o(credit_err_o)
   );

   always #5 clk_i = ~clk_i;

   int nv = 0;
   int nerr = 0;
   int src_cnt[N];
   int src_len[N];
   int src_pos[N];
   int exp_q[$];
   int left;
   bit in_pkt;
   bit fired;
   int nfire;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nv++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int c = 0; c < N; c++) begin
         in_valid_i[c]      = (src_cnt[c] != 0);
         in_is_header_i[c]  = (src_pos[c] == 0);
         in_len_i[c*8 +: 8] = src_len[c][7:0];
      end
   endtask

   // One clock: observe the handshake at negedge, advance sources after the edge.
   task automatic tick();
      logic [N-1:0] hs;
      int e;
      @(negedge clk_i);
      fired = 1'b0;
      hs = in_valid_i & in_ready_o;
      if (rst_n_i === 1'b1 && out_valid_o === 1'b1 && out_ready_i) begin
         fired = 1'b1;
         nfire++;
         if (!in_pkt) begin
            nv++;
            assert (exp_q.size() != 0) else begin
               nerr++;
               $error("FAIL unexpected_header got grant %0d expected none", grant_o);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("grant_order", 32'(grant_o), e);
               left = src_len[e];
               in_pkt = (left != 0);
            end
         end else begin
            left--;
            in_pkt = (left != 0);
         end
      end
      @(posedge clk_i);
      #1;
      for (int c = 0; c < N; c++) begin
         if (hs[c]) begin
            if (src_pos[c] == src_len[c]) begin
               src_pos[c] = 0;
               src_cnt[c]--;
            end else begin
               src_pos[c]++;
            end
         end
      end
      drive();
      #1;
   endtask

   task automatic give_credits(input int n);
      credit_return_i = 1'b1;
      repeat (n) tick();
      credit_return_i = 1'b0;
   endtask

   task automatic clear_src();
      for (int c = 0; c < N; c++) begin
         src_cnt[c] = 0; src_len[c] = 0; src_pos[c] = 0;
      end
      exp_q.delete();
      in_pkt = 1'b0;
      left = 0;
   endtask

   initial begin
      rst_n_i = 1'b0;
      out_ready_i = 1'b1;
      credit_return_i = 1'b0;
      for (int c = 0; c < N; c++) weight_i[c*4 +: 4] = 4'd1;
      clear_src();
      nfire = 0;
      drive();
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_grant", 32'(grant_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_in_ready", 32'(in_ready_o), 0);
      chk("rst_out_valid", 32'(out_valid_o), 0);
      chk("rst_credits", 32'(credits_o), 8);
      chk("rst_err", 32'(credit_err_o), 0);
      rst_n_i = 1'b1;

      // Round robin 0,1,3,0 with LEN=1, one arbitration cycle per packet
      src_len[0] = 1; src_cnt[0] = 2;
      src_len[1] = 1; src_cnt[1] = 1;
      src_len[3] = 1; src_cnt[3] = 1;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(0);
      drive();
      nfire = 0;
      repeat (12) tick();
      chk("rr_fires", nfire, 8);
      chk("rr_busy_end", 32'(busy_o), 0);
      chk("rr_sb_empty", exp_q.size(), 0);
      chk("rr_credits", 32'(credits_o), 0);
      give_credits(8);
      chk("refill_credits", 32'(credits_o), 8);
      chk("refill_err", 32'(credit_err_o), 0);

      // Single packet ch2 LEN=3
      src_len[2] = 3; src_cnt[2] = 1;
      exp_q.push_back(2);
      drive();
      tick();
      chk("sp_grant", 32'(grant_o), 2);
      chk("sp_busy", 32'(busy_o), 1);
      chk("sp_bubble", 32'(fired), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("sp_fire", 32'(fired), 1);
      end
      chk("sp_busy_end", 32'(busy_o), 0);
      chk("sp_credits", 32'(credits_o), 4);
      give_credits(4);

      // Weighted: ch1 quota 3, ch2 quota 1, LEN=0
      weight_i[1*4 +: 4] = 4'd3;
      src_len[1] = 0; src_cnt[1] = 6;
      src_len[2] = 0; src_cnt[2] = 2;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2);
      end
      drive();
      nfire = 0;
      repeat (16) tick();
      chk("wrr_fires", nfire, 8);
      chk("wrr_sb_empty", exp_q.size(), 0);
      give_credits(2);
      chk("stall_credits_start", 32'(credits_o), 2);

      // Credit stall: two credits, LEN=4 on ch0
      src_len[0] = 4; src_cnt[0] = 1;
      exp_q.push_back(0);
      drive();
      tick();
      chk("st_grant", 32'(grant_o), 0);
      tick(); chk("st_hdr_fire", 32'(fired), 1);
      tick(); chk("st_p1_fire", 32'(fired), 1);
      tick(); chk("st_stalled", 32'(fired), 0);
      chk("st_out_valid", 32'(out_valid_o), 0);
      chk("st_grant_held", 32'(grant_o), 0);
      chk("st_busy_held", 32'(busy_o), 1);
      chk("st_credits0", 32'(credits_o), 0);
      give_credits(1);
      chk("st_ret_credits", 32'(credits_o), 1);
      tick(); chk("st_one_more", 32'(fired), 1);
      tick(); chk("st_stalled2", 32'(fired), 0);
      give_credits(1);
      credit_return_i = 1'b1;
      tick();
      credit_return_i = 1'b0;
      chk("sim_fire_ret_fired", 32'(fired), 1);
      chk("sim_fire_ret_credits", 32'(credits_o), 1);
      tick(); chk("st_last_fire", 32'(fired), 1);
      chk("st_busy_end", 32'(busy_o), 0);
      chk("st_sb_empty", exp_q.size(), 0);
      give_credits(8);
      chk("ovf_before", 32'(credit_err_o), 0);
      give_credits(1);
      chk("ovf_credits", 32'(credits_o), 8);
      repeat (3) tick();
      chk("ovf_sticky", 32'(credit_err_o), 1);

      // Reset mid-packet after 2 of 5 beats
      src_len[4] = 4; src_cnt[4] = 1;
      exp_q.push_back(4);
      drive();
      nfire = 0;
      repeat (3) tick();
      chk("mid_grant", 32'(grant_o), 4);
      chk("mid_fires", nfire, 2);
      rst_n_i = 1'b0;
      #1;
      chk("mrst_grant", 32'(grant_o), 0);
      chk("mrst_busy", 32'(busy_o), 0);
      chk("mrst_in_ready", 32'(in_ready_o), 0);
      chk("mrst_out_valid", 32'(out_valid_o), 0);
      chk("mrst_credits", 32'(credits_o), 8);
      chk("mrst_err", 32'(credit_err_o), 0);
      clear_src();
      drive();
      tick();
      rst_n_i = 1'b1;
      src_cnt[0] = 1; src_cnt[4] = 1;
      exp_q.push_back(0); exp_q.push_back(4);
      drive();
      nfire = 0;
      tick();
      chk("post_rst_grant", 32'(grant_o), 0);
      repeat (3) tick();
      chk("post_rst_fires", nfire, 2);
      chk("post_rst_sb_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
      $finish;
   end
endmodule
